// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg -- shared types for the frequency meter.
//   STATE_W : width of the controller state encoding
//   state_t : controller states (IDLE, GATE, LATCH)
package freq_meter_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        GATE  = 2'd1,
        LATCH = 2'd2
    } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det -- 2-flop synchronizer followed by a registered rising-edge
// detector. rise_pulse is high for one clk cycle, two cycles after async_in
// is first sampled high.
//   clk        : system clock
//   rst_n_a    : asynchronous active-low reset
//   async_in   : asynchronous input
//   rise_pulse : registered one-cycle pulse per synchronized rising edge
module sync_edge_det (
    input  logic clk,
    input  logic rst_n_a,
    input  logic async_in,
    output logic rise_pulse
);

    logic meta;
    logic sync;
    logic sync_d;

    always_ff @(posedge clk or negedge rst_n_a) begin
        if (!rst_n_a) begin
            meta       <= 1'b0;
            sync       <= 1'b0;
            sync_d     <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            meta       <= async_in;
            sync       <= meta;
            sync_d     <= sync;
            rise_pulse <= sync & ~sync_d;
        end
    end

endmodule

// File: rtl/freq_meter.sv
// freq_meter -- counts rising edges of sig_in over a gate window of
// GATE_CYCLES clk cycles and publishes the count after each window.
//
// Optional build macro: FREQ_METER_SATURATE_EN
//   defined   -> edge counter saturates at all-ones
//   undefined -> edge counter wraps to zero
//   overflow reports an over-range window in both builds.
//
// Ports:
//   clk        : system clock, all state on the rising edge
//   rst_n_a    : asynchronous active-low reset
//   enable     : 1 = measure continuously
//   sig_in     : asynchronous signal under measurement
//   freq_count : edges counted in the last completed window
//   valid      : one-cycle pulse, aligned with a freq_count update
//   overflow   : last completed window exceeded 2^CNT_W-1 edges
//   LED_GATE   : high while the gate window is open
//
// State  | meaning
// IDLE   | timer and edge counter held at 0, waiting for enable
// GATE   | window open: timer runs, edges are counted
// LATCH  | one cycle: publish count/overflow, edges ignored
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = 100,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n_a,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq_count,
    output logic             valid,
    output logic             overflow,
    output logic             LED_GATE
);

    localparam int               TMR_W    = $clog2(GATE_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state;
    state_t           state_nxt;
    logic [TMR_W-1:0] timer;
    logic [CNT_W-1:0] edge_cnt;
    logic             ovf_sticky;
    logic             rise_pulse;
    logic             gate_done;
    logic             in_gate;
    logic             do_latch;

    sync_edge_det u_sync_edge_det (
        .clk        (clk),
        .rst_n_a    (rst_n_a),
        .async_in   (sig_in),
        .rise_pulse (rise_pulse)
    );

    assign gate_done = (timer == TMR_LAST);

    always_ff @(posedge clk or negedge rst_n_a) begin
        if (!rst_n_a) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Dropping enable wins over window completion, so an abort in the
    // final GATE cycle still produces no result.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = GATE;
            GATE: begin
                if (!enable)        state_nxt = IDLE;
                else if (gate_done) state_nxt = LATCH;
            end
            LATCH:   state_nxt = enable ? GATE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_gate  = (state == GATE);
        do_latch = (state == LATCH);
        LED_GATE = in_gate;
    end

    always_ff @(posedge clk or negedge rst_n_a) begin
        if (!rst_n_a) begin
            timer <= '0;
        end else if (in_gate && !gate_done) begin
            timer <= timer + TMR_W'(1);
        end else begin
            timer <= '0;
        end
    end

    // Counter and sticky clear outside GATE; LATCH samples them on the same
    // edge that clears them, so the next window starts from zero.
    always_ff @(posedge clk or negedge rst_n_a) begin
        if (!rst_n_a) begin
            edge_cnt   <= '0;
            ovf_sticky <= 1'b0;
        end else if (!in_gate) begin
            edge_cnt   <= '0;
            ovf_sticky <= 1'b0;
        end else if (rise_pulse) begin
            if (edge_cnt == CNT_MAX) begin
                ovf_sticky <= 1'b1;
`ifdef FREQ_METER_SATURATE_EN
                edge_cnt   <= CNT_MAX;
`else
                edge_cnt   <= '0;
`endif
            end else begin
                edge_cnt <= edge_cnt + CNT_W'(1);
            end
        end
    end

    // valid is registered so it rises together with the new freq_count.
    always_ff @(posedge clk or negedge rst_n_a) begin
        if (!rst_n_a) begin
            freq_count <= '0;
            overflow   <= 1'b0;
            valid      <= 1'b0;
        end else begin
            valid <= do_latch;
            if (do_latch) begin
                freq_count <= edge_cnt;
                overflow   <= ovf_sticky;
            end
        end
    end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 Parameter GATE_CYCLES, default 100, gate window length in clk cycles (>=2).
REQ-002 Parameter CNT_W, default 8, width of the edge counter and result.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 rst_n_a  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  synchronous run request; 1 = measure continuously.
REQ-006 sig_in  input  1  asynchronous signal under measurement (e.g. divided clock).
REQ-007 freq_count  output  CNT_W  rising edges counted in the last completed gate window.
REQ-008 valid  output  1  one-cycle pulse when freq_count is updated.
REQ-009 overflow  output  1  edge count of the last completed window exceeded 2^CNT_W-1.
REQ-010 LED_GATE  output  1  high while state is GATE.

Function
REQ-011 sig_in SHALL pass through a 2-flop synchronizer, then a registered rising-edge detector; edge-to-count latency is 3 clk cycles.
REQ-012 FSM states SHALL be IDLE, GATE, LATCH.
REQ-013 IDLE: timer and edge counter held at 0; enable=1 -> GATE next cycle.
REQ-014 GATE: timer increments each cycle; each detected edge increments the edge counter; GATE lasts exactly GATE_CYCLES cycles, exit when timer==GATE_CYCLES-1.
REQ-015 An edge detected in the final GATE cycle SHALL be counted.
REQ-016 LATCH (one cycle): freq_count <= edge counter, overflow <= overflow-sticky, valid=1; edges detected in LATCH are not counted (1-cycle dead time).
REQ-017 From LATCH: enable=1 -> GATE with timer, counter and sticky cleared; enable=0 -> IDLE.
REQ-018 enable=0 during GATE SHALL abort to IDLE next cycle; freq_count, overflow unchanged; no valid pulse.
REQ-019 Edge counter at 2^CNT_W-1 receiving another edge SHALL set overflow-sticky; counter value per REQ-025.
REQ-020 freq_count and overflow SHALL hold between LATCH cycles.

Reset
REQ-021 rst_n_a low SHALL immediately force state IDLE, synchronizer flops 0, timer 0, edge counter 0, overflow-sticky 0.
REQ-022 Reset values: freq_count=0, valid=0, overflow=0, LED_GATE=0.
REQ-023 Reset mid-GATE discards the partial window; measurement restarts only after release and enable=1.
REQ-024 After release, first valid pulse no earlier than GATE_CYCLES+2 cycles after enable is sampled high.

Configuration
REQ-025 Macro FREQ_METER_SATURATE_EN: defined -> edge counter saturates at 2^CNT_W-1; undefined -> edge counter wraps to 0; overflow flag behaves identically in both builds.

Structure
REQ-026 Package freq_meter_pkg SHALL hold the state enum (IDLE, GATE, LATCH) and the state width constant.
REQ-027 Sub-module sync_edge_det SHALL contain the 2-flop synchronizer and rising-edge detector (inputs clk, rst_n_a, async_in; output rise_pulse).
REQ-028 Timer width SHALL be $clog2(GATE_CYCLES); no other sub-modules.

Verification (GATE_CYCLES=100, CNT_W=8)
REQ-029 sig_in toggling every 5 clk (period 10), enable=1 -> valid every 101 cycles, freq_count=10 (+/-1), overflow=0.
REQ-030 sig_in period 2 (toggle every clk) -> 50 edges per window, freq_count=50 (+/-1).
REQ-031 Saturate build, sig_in period 2, GATE_CYCLES=600 -> freq_count=255, overflow=1; wrap build -> freq_count=(300 mod 256)=44 (+/-1), overflow=1.
REQ-032 enable dropped at GATE cycle 40 -> no valid, freq_count retains previous value, LED_GATE=0 next cycle.
REQ-033 rst_n_a pulsed low asynchronously mid-GATE -> all outputs 0 immediately; after release and enable=1, first valid after >=102 cycles.
REQ-034 sig_in constant 1 -> freq_count=0 every window, valid still pulses.
